// File: rtl/async_pkg.sv
// Shared types and helpers for the async req/ack merge node.
//   merge_state_t  : merge FSM states
//   DEF_DATA_WIDTH : default token width
//   clog2_min1     : $clog2 clamped to a minimum of 1 bit
package async_pkg;

  typedef enum logic [2:0] {SEL, REQ, DRAIN, HOLD, ACK} merge_state_t;

  localparam int DEF_DATA_WIDTH = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_timer.sv
// Per-request timeout counter for the merge node.
//   clk, rst  : clock, async active-high reset
//   clr_i     : reset the count to 0 (takes priority over en_i)
//   en_i      : count one cycle
//   expire_o  : high in the enabled cycle where the count reaches TIMEOUT-1
module rr_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // The owner leaves the counting state on expiry, so the count never
  // goes past TIMEOUT-1 and $clog2(TIMEOUT) bits suffice.
  localparam int TW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/async_rr_merge.sv
// N-to-1 round-robin merge node for the async req/ack dataflow fabric.
// Pulls one token at a time from each source in turn, tags it with its
// source index and hands it to a single downstream consumer.
//   clk, rst  : clock, async active-high reset
//   req_l     : per-source pull request (at most one bit high)
//   ack_l     : per-source one-cycle ack, din slice valid with it
//   din       : packed source tokens, slice i = source i
//   req_r     : downstream pull request (level)
//   ack_r     : one-cycle ack to downstream, dout/dout_src valid with it
//   dout      : forwarded token, held until the next capture
//   dout_src  : source index of dout
// Optional (ASYNC_RR_MERGE_PERF_EN):
//   grant_cnt : per-source delivered-token counters, 32 bits each
//   skip_cnt  : number of timeouts that ended without a capture
module async_rr_merge
  import async_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 16,
  parameter int SRC_W      = clog2_min1(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [NUM_SRC-1:0]            req_l,
  input  logic [NUM_SRC-1:0]            ack_l,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] din,
  input  logic                          req_r,
  output logic                          ack_r,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [SRC_W-1:0]              dout_src
`ifdef ASYNC_RR_MERGE_PERF_EN
  ,
  output logic [NUM_SRC*32-1:0]         grant_cnt,
  output logic [31:0]                   skip_cnt
`endif
);

  merge_state_t                         state_q, state_d;
  logic [SRC_W-1:0]                     sel_q, sel_d, ptr_q, ptr_d, nxt;
  logic [DATA_WIDTH-1:0]                dout_q, dout_d;
  logic [SRC_W-1:0]                     src_q, src_d;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   din_v;
  logic                                 ack_sel, tmr_clr, tmr_en, tmr_exp;

  assign din_v   = din;
  assign ack_sel = ack_l[sel_q];
  assign nxt     = (sel_q == SRC_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  rr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    src_d   = src_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      SEL: begin
        sel_d   = ptr_q;
        tmr_clr = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        tmr_en = 1'b1;
        // a capture in the expiry cycle wins over the skip
        if (ack_sel) begin
          dout_d  = din_v[sel_q];
          src_d   = sel_q;
          state_d = HOLD;
        end else if (tmr_exp) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // one grace cycle for a registered producer whose ack was already
        // launched when req_l dropped
        if (ack_sel) begin
          dout_d  = din_v[sel_q];
          src_d   = sel_q;
          state_d = HOLD;
        end else begin
          ptr_d   = nxt;
          state_d = SEL;
        end
      end
      HOLD: if (req_r) state_d = ACK;
      ACK: begin
        ptr_d   = nxt;
        state_d = SEL;
      end
      default: state_d = SEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEL;
      sel_q   <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
    end
  end

  // all outputs decode registered state only
  assign req_l    = (state_q == REQ) ? (NUM_SRC'(1) << sel_q) : '0;
  assign ack_r    = (state_q == ACK);
  assign dout     = dout_q;
  assign dout_src = src_q;

`ifdef ASYNC_RR_MERGE_PERF_EN
  logic [NUM_SRC-1:0][31:0] grant_q;
  logic [31:0]              skip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      skip_q  <= '0;
    end else begin
      if (state_q == ACK)                grant_q[sel_q] <= grant_q[sel_q] + 32'd1;
      if (state_q == DRAIN && !ack_sel)  skip_q         <= skip_q + 32'd1;
    end
  end

  assign grant_cnt = grant_q;
  assign skip_cnt  = skip_q;
`endif

endmodule

// File: tb/tb_async_rr_merge.sv
// Directed bench for async_rr_merge: NUM_SRC=3, DATA_WIDTH=8, TIMEOUT=4.
// Source i token = {i[1:0], seq[5:0]}, seq advancing on each ack it gives.
module tb_async_rr_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_l, ack_l;
  logic [23:0] din;
  logic        req_r, ack_r;
  logic [7:0]  dout;
  logic [1:0]  dout_src;
`ifdef ASYNC_RR_MERGE_PERF_EN
  logic [95:0] grant_cnt;
  logic [31:0] skip_cnt;
`endif

  async_rr_merge #(.NUM_SRC(3), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_l    (req_l),
    .ack_l    (ack_l),
    .din      (din),
    .req_r    (req_r),
    .ack_r    (ack_r),
    .dout     (dout),
    .dout_src (dout_src)
`ifdef ASYNC_RR_MERGE_PERF_EN
    ,
    .grant_cnt(grant_cnt),
    .skip_cnt (skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [2:0]  ready, late, prev_req;
  logic        prev_ack;
  logic [5:0]  tok [3];
  logic [1:0]  got_src [$];
  logic [7:0]  got_dat [$];
  logic [2:0]  tr_exp [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tok(input string tag, input int idx, input logic [1:0] s, input logic [7:0] d);
    chk({tag, "_present"}, 32'(got_src.size() > idx), 32'd1);
    if (got_src.size() > idx) begin
      chk({tag, "_src"}, 32'(got_src[idx]), 32'(s));
      chk({tag, "_dat"}, 32'(got_dat[idx]), 32'(d));
    end
  endtask

  task automatic set_din();
    din = {2'd2, tok[2], 2'd1, tok[1], 2'd0, tok[0]};
  endtask

  // one clock: account acks taken at the edge, sample outputs at +1,
  // then drive the producer model for the next edge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) if (ack_l[i]) tok[i] = tok[i] + 6'd1;
    #1;
    if (ack_r) begin
      chk("ack_r_not_adjacent", 32'(prev_ack), 32'd0);
      got_src.push_back(dout_src);
      got_dat.push_back(dout);
    end
    prev_ack = ack_r;
    ack_l    = (req_l & ready) | (late & prev_req & ~req_l);
    prev_req = req_l;
    set_din();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack_l = '0; prev_req = '0; prev_ack = 1'b0;
    for (int i = 0; i < 3; i++) tok[i] = '0;
    set_din();
    got_src.delete(); got_dat.delete();
    @(posedge clk); #1;
    chk("rst_req_l", 32'(req_l), 32'd0);
    chk("rst_ack_r", 32'(ack_r), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_src", 32'(dout_src), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ack_l = '0; din = '0; req_r = 1'b0;
    ready = '0; late = '0; prev_req = '0; prev_ack = 1'b0;

    // 1: all producers ready, consumer always pulling; 4-cycle rounds, wrap 2->0
    do_reset();
    ready = 3'b111; req_r = 1'b1;
    run(24);
    chk("p1_count", 32'(got_src.size()), 32'd6);
    chk_tok("p1_t0", 0, 2'd0, 8'h00);
    chk_tok("p1_t1", 1, 2'd1, 8'h40);
    chk_tok("p1_t2", 2, 2'd2, 8'h80);
    chk_tok("p1_t3", 3, 2'd0, 8'h01);
    chk_tok("p1_t4", 4, 2'd1, 8'h41);
    chk_tok("p1_t5", 5, 2'd2, 8'h81);
`ifdef ASYNC_RR_MERGE_PERF_EN
    chk("p1_grant0", grant_cnt[31:0], 32'd2);
    chk("p1_skip", skip_cnt, 32'd0);
`endif

    // 2: source 0 silent -> req_l[0] for 4 cycles, DRAIN, SEL, then source 1
    do_reset();
    ready = 3'b110; req_r = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("p2_req_l_c%0d", k), 32'(req_l), 32'(tr_exp[k]));
    end
    run(23);
    chk("p2_count", 32'(got_src.size()), 32'd4);
    chk_tok("p2_t0", 0, 2'd1, 8'h40);
    chk_tok("p2_t1", 1, 2'd2, 8'h80);
    chk_tok("p2_t2", 2, 2'd1, 8'h41);
    chk_tok("p2_t3", 3, 2'd2, 8'h81);
`ifdef ASYNC_RR_MERGE_PERF_EN
    chk("p2_skip", skip_cnt, 32'd2);
`endif

    // 3: source 0 acks one cycle after req_l drops -> captured in DRAIN
    do_reset();
    ready = 3'b110; late = 3'b001; req_r = 1'b1;
    run(12);
    chk("p3_count", 32'(got_src.size()), 32'd2);
    chk_tok("p3_t0", 0, 2'd0, 8'h00);
    chk_tok("p3_t1", 1, 2'd1, 8'h40);
`ifdef ASYNC_RR_MERGE_PERF_EN
    chk("p3_skip", skip_cnt, 32'd0);
    chk("p3_grant0", grant_cnt[31:0], 32'd1);
`endif
    late = '0;

    // 4: consumer idle in HOLD; stray acks ignored; token delivered once
    do_reset();
    ready = 3'b111; req_r = 1'b0;
    run(10);
    chk("p4_no_deliv", 32'(got_src.size()), 32'd0);
    chk("p4_req_l_idle", 32'(req_l), 32'd0);
    ack_l = 3'b111; din = '1;
    @(posedge clk); #1;
    ack_l = '0; set_din();
    chk("p4_held_dout", 32'(dout), 32'h00);
    chk("p4_held_src", 32'(dout_src), 32'd0);
    req_r = 1'b1;
    run(8);
    chk("p4_count", 32'(got_src.size()), 32'd2);
    chk_tok("p4_t0", 0, 2'd0, 8'h00);
    chk_tok("p4_t1", 1, 2'd1, 8'h40);

    // 5: async reset while holding token 0x05; it must never appear
    do_reset();
    ready = 3'b111; req_r = 1'b0;
    tok[0] = 6'd5; set_din();
    run(3);
    chk("p5_pre_dout", 32'(dout), 32'h05);
    #2 rst = 1'b1;
    #1;
    chk("p5_async_ack_r", 32'(ack_r), 32'd0);
    chk("p5_async_req_l", 32'(req_l), 32'd0);
    chk("p5_async_dout", 32'(dout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ack_l = '0; prev_req = '0; prev_ack = 1'b0; set_din();
    req_r = 1'b1;
    tick();
    chk("p5_first_req", 32'(req_l), 32'b001);
    run(7);
    chk("p5_count", 32'(got_src.size()), 32'd2);
    chk_tok("p5_t0", 0, 2'd0, 8'h06);
    chk_tok("p5_t1", 1, 2'd1, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
